pkt_stream_checker: RTL and testbench
=====================================

PKT_STREAM_CHECKER -- requirements
Module: pkt_stream_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning stream data width in bits.
REQ-002 SHALL have parameter CHAN_W, default 6, meaning channel field width.
REQ-003 SHALL have parameter NCHAN, default 4, meaning number of checked channels (1..2^CHAN_W).
REQ-004 SHALL have parameter TAG_W, default 6, meaning sequence tag width.
REQ-005 SHALL have parameter TAG_LSB, default 0, meaning bit position of the tag within st_data on SOP beats.
REQ-006 SHALL have parameter EMPTY_W, default 4, meaning empty field width.
REQ-007 SHALL have parameters MIN_BEATS, default 2, and MAX_BEATS, default 64, meaning the legal packet length range in beats.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-010 SHALL have input ports st_data [DATA_W], st_valid, st_ready, st_sop, st_eop, st_empty [EMPTY_W] and st_channel [CHAN_W], all passively observed.
REQ-011 SHALL have input port clear_err, 1 bit: synchronous clear of error state.
REQ-012 SHALL have output port err_sticky, 5 bits: {badchan, length, empty, tag, framing}.
REQ-013 SHALL have output port err_pulse, 1 bit: one-cycle strobe on any new error.
REQ-014 SHALL have output ports first_err_code [3] and first_err_chan [CHAN_W]: capture of the first error since reset or clear.
REQ-015 SHALL have output port pkt_count, 32 bits: count of completed packets across all channels, wrapping.

Function
REQ-016 A beat SHALL be accepted only when st_valid & st_ready; all other cycles SHALL be ignored.
REQ-017 Each channel SHALL hold an independent state machine with states IDLE and IN_PKT, plus exp_tag [TAG_W], exp_empty [EMPTY_W] and beat_cnt [16, saturating].
REQ-018 On SOP in IDLE, the block SHALL compare the tag with exp_tag, set exp_tag to tag+1 (resync, mod 2^TAG_W), set beat_cnt to 1 and go to IN_PKT; a mismatch SHALL raise a tag error.
REQ-019 On SOP in IN_PKT, the block SHALL raise a framing error and then treat the beat as a fresh SOP per REQ-018.
REQ-020 A non-SOP beat in IDLE SHALL raise a framing error and be discarded, with the state remaining IDLE.
REQ-021 On EOP, the block SHALL raise an empty error if st_empty != exp_empty, increment exp_empty (wrap), increment pkt_count, and return to IDLE.
REQ-022 A beat with SOP and EOP together SHALL be a 1-beat packet, applying REQ-018 and then REQ-021.
REQ-023 On a beat with st_channel >= NCHAN, the block SHALL raise a badchan error and leave all channel state untouched.
REQ-024 All error outputs SHALL be registered with 1-cycle latency after the offending beat.
REQ-025 err_sticky bits SHALL stay set until clear_err; if clear_err and a new error occur in the same cycle, the new error SHALL be set.
REQ-026 first_err_code SHALL be encoded 0=framing, 1=tag, 2=empty, 3=length, 4=badchan, with the lowest code winning on simultaneous errors; it SHALL be loaded only when err_sticky is zero (after clear).
REQ-027 err_pulse SHALL be high for exactly one cycle per beat producing at least one error.

Reset
REQ-028 On reset_n low, asynchronously: all channels SHALL go to IDLE, exp_tag=0, exp_empty=0, beat_cnt=0, err_sticky=0, err_pulse=0, first_err_code=0, first_err_chan=0, pkt_count=0.
REQ-029 Reset mid-packet SHALL drop in-flight state, so the next non-SOP beat on that channel is a framing error.

Configuration
REQ-030 With macro PKT_CHECK_LEN_EN defined, the block SHALL raise a length error on EOP if beat_cnt < MIN_BEATS or beat_cnt > MAX_BEATS (saturated counts included).
REQ-031 Without PKT_CHECK_LEN_EN, the beat counters and length logic SHALL be absent and err_sticky[3] SHALL be tied to 0.

Verification
REQ-032 Send 3 six-beat packets on ch0 with tags 0,1,2 and empty 0,1,2 -> pkt_count=3, err_sticky=0, err_pulse never high.
REQ-033 Send ch1 tags 0 then 5 -> err_sticky=5'b00010, first_err_code=1, first_err_chan=1; a following tag 6 -> no new error.
REQ-034 Send a non-SOP beat on idle ch2, then SOP twice without EOP -> two err_pulses, first_err_code=0, first_err_chan=2.
REQ-035 Send ch=NCHAN (4) with valid&ready -> err_sticky[4]=1; assert clear_err -> err_sticky=0 next cycle.
REQ-036 With PKT_CHECK_LEN_EN defined, send a 1-beat packet and a 65-beat packet -> err_sticky[3]=1 for each; without it -> err_sticky[3]=0.
REQ-037 Assert reset_n low for one cycle mid-packet on ch0 -> all outputs 0 immediately; a continuation beat -> framing error.

Source files
------------

// File: rtl/pkt_stream_checker.sv
// Passive per-channel protocol checker for a channelised SOP/EOP packet stream.
// Define PKT_CHECK_LEN_EN to add packet length checking (MIN_BEATS..MAX_BEATS).
module pkt_stream_checker #(
    parameter int DATA_W    = 128,
    parameter int CHAN_W    = 6,
    parameter int NCHAN     = 4,
    parameter int TAG_W     = 6,
    parameter int TAG_LSB   = 0,
    parameter int EMPTY_W   = 4,
    parameter int MIN_BEATS = 2,
    parameter int MAX_BEATS = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  st_data,
    input  logic               st_valid,
    input  logic               st_ready,
    input  logic               st_sop,
    input  logic               st_eop,
    input  logic [EMPTY_W-1:0] st_empty,
    input  logic [CHAN_W-1:0]  st_channel,
    input  logic               clear_err,
    output logic [4:0]         err_sticky,
    output logic               err_pulse,
    output logic [2:0]         first_err_code,
    output logic [CHAN_W-1:0]  first_err_chan,
    output logic [31:0]        pkt_count
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } chan_state_t;

    localparam int             CIDX_W    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam logic [CHAN_W:0] NCHAN_CMP = (CHAN_W + 1)'(NCHAN);

    // Error vector bit order: {badchan, length, empty, tag, framing}; lowest code wins.
    function automatic logic [2:0] first_code(input logic [4:0] err);
        logic [2:0] code;
        casez (err)
            5'b????1: code = 3'd0;
            5'b???10: code = 3'd1;
            5'b??100: code = 3'd2;
            5'b?1000: code = 3'd3;
            5'b10000: code = 3'd4;
            default:  code = 3'd0;
        endcase
        return code;
    endfunction

    chan_state_t        state_r         [NCHAN];
    chan_state_t        state_nxt_s     [NCHAN];
    logic [TAG_W-1:0]   exp_tag_r       [NCHAN];
    logic [TAG_W-1:0]   exp_tag_nxt_s   [NCHAN];
    logic [EMPTY_W-1:0] exp_empty_r     [NCHAN];
    logic [EMPTY_W-1:0] exp_empty_nxt_s [NCHAN];
`ifdef PKT_CHECK_LEN_EN
    logic [15:0]        beat_cnt_r      [NCHAN];
    logic [15:0]        beat_cnt_nxt_s  [NCHAN];
`endif

    logic               accept_s;
    logic               chan_ok_s;
    logic               beat_ok_s;
    logic [CIDX_W-1:0]  ch_idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [4:0]         new_err_s;
    logic               pkt_inc_s;
    logic               unused_s;

    logic [4:0]         err_sticky_r;
    logic               err_pulse_r;
    logic [2:0]         first_err_code_r;
    logic [CHAN_W-1:0]  first_err_chan_r;
    logic [31:0]        pkt_count_r;

    assign accept_s  = st_valid & st_ready;
    assign chan_ok_s = ({1'b0, st_channel} < NCHAN_CMP);
    assign beat_ok_s = accept_s & chan_ok_s;
    assign ch_idx_s  = st_channel[CIDX_W-1:0];
    assign tag_s     = st_data[TAG_LSB +: TAG_W];

`ifdef PKT_CHECK_LEN_EN
    assign unused_s = ^st_data;
`else
    assign unused_s = ^{st_data, 32'(MIN_BEATS), 32'(MAX_BEATS)};
`endif

    // Per-channel next state and error detection for the accepted beat
    always_comb begin
        logic start_v;
        logic finish_v;
`ifdef PKT_CHECK_LEN_EN
        logic [15:0] len_v;
        len_v = 16'd0;
`endif
        start_v   = 1'b0;
        finish_v  = 1'b0;
        new_err_s = 5'b00000;
        pkt_inc_s = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            state_nxt_s[i]     = state_r[i];
            exp_tag_nxt_s[i]   = exp_tag_r[i];
            exp_empty_nxt_s[i] = exp_empty_r[i];
            start_v            = 1'b0;
            finish_v           = 1'b0;
`ifdef PKT_CHECK_LEN_EN
            beat_cnt_nxt_s[i]  = beat_cnt_r[i];
            len_v              = beat_cnt_r[i];
`endif
            if (beat_ok_s && (ch_idx_s == CIDX_W'(i))) begin
                case (state_r[i])
                    IDLE: begin
                        start_v      = st_sop;
                        new_err_s[0] = ~st_sop;
                    end
                    IN_PKT: begin
                        // A second SOP closes the broken packet and restarts cleanly
                        new_err_s[0] = st_sop;
                        start_v      = st_sop;
                        finish_v     = ~st_sop & st_eop;
`ifdef PKT_CHECK_LEN_EN
                        len_v = (beat_cnt_r[i] == 16'hFFFF) ? 16'hFFFF : beat_cnt_r[i] + 16'd1;
`endif
                    end
                    default: begin
                        new_err_s[0]   = 1'b1;
                        state_nxt_s[i] = IDLE;
                    end
                endcase

                if (start_v) begin
                    new_err_s[1]     = (tag_s != exp_tag_r[i]);
                    exp_tag_nxt_s[i] = tag_s + TAG_W'(1);
                    state_nxt_s[i]   = IN_PKT;
                    finish_v         = st_eop;
`ifdef PKT_CHECK_LEN_EN
                    len_v            = 16'd1;
`endif
                end else begin
                    exp_tag_nxt_s[i] = exp_tag_r[i];
                end

                if (finish_v) begin
                    new_err_s[2]       = (st_empty != exp_empty_r[i]);
                    exp_empty_nxt_s[i] = exp_empty_r[i] + EMPTY_W'(1);
                    pkt_inc_s          = 1'b1;
                    state_nxt_s[i]     = IDLE;
`ifdef PKT_CHECK_LEN_EN
                    new_err_s[3] = ({16'd0, len_v} < 32'(MIN_BEATS)) ||
                                   ({16'd0, len_v} > 32'(MAX_BEATS));
`endif
                end else begin
                    exp_empty_nxt_s[i] = exp_empty_r[i];
                end
`ifdef PKT_CHECK_LEN_EN
                beat_cnt_nxt_s[i] = len_v;
`endif
            end else begin
                state_nxt_s[i] = state_r[i];
            end
        end
        new_err_s[4] = accept_s & ~chan_ok_s;
    end

    // Per-channel state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                state_r[i]     <= IDLE;
                exp_tag_r[i]   <= {TAG_W{1'b0}};
                exp_empty_r[i] <= {EMPTY_W{1'b0}};
`ifdef PKT_CHECK_LEN_EN
                beat_cnt_r[i]  <= 16'd0;
`endif
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                state_r[i]     <= state_nxt_s[i];
                exp_tag_r[i]   <= exp_tag_nxt_s[i];
                exp_empty_r[i] <= exp_empty_nxt_s[i];
`ifdef PKT_CHECK_LEN_EN
                beat_cnt_r[i]  <= beat_cnt_nxt_s[i];
`endif
            end
        end
    end

    // Error reporting and packet counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky_r     <= 5'b00000;
            err_pulse_r      <= 1'b0;
            first_err_code_r <= 3'd0;
            first_err_chan_r <= {CHAN_W{1'b0}};
            pkt_count_r      <= 32'd0;
        end else begin
            err_pulse_r <= |new_err_s;
            // A new error in the clearing cycle survives the clear
            if (clear_err) begin
                err_sticky_r <= new_err_s;
            end else begin
                err_sticky_r <= err_sticky_r | new_err_s;
            end
            if ((|new_err_s) && (clear_err || (err_sticky_r == 5'b00000))) begin
                first_err_code_r <= first_code(new_err_s);
                first_err_chan_r <= st_channel;
            end else if (clear_err) begin
                first_err_code_r <= 3'd0;
                first_err_chan_r <= {CHAN_W{1'b0}};
            end else begin
                first_err_code_r <= first_err_code_r;
                first_err_chan_r <= first_err_chan_r;
            end
            if (pkt_inc_s) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end else begin
                pkt_count_r <= pkt_count_r;
            end
        end
    end

    assign err_sticky     = err_sticky_r;
    assign err_pulse      = err_pulse_r;
    assign first_err_code = first_err_code_r;
    assign first_err_chan = first_err_chan_r;
    assign pkt_count      = pkt_count_r;

endmodule

// File: tb/tb_pkt_stream_checker.sv
// Self-checking bench for pkt_stream_checker: directed scenarios plus random beats
// compared against a per-channel behavioural model.
module tb_pkt_stream_checker;

    localparam int DATA_W    = 128;
    localparam int CHAN_W    = 6;
    localparam int NCHAN     = 4;
    localparam int TAG_W     = 6;
    localparam int EMPTY_W   = 4;
    localparam int MIN_BEATS = 2;
    localparam int MAX_BEATS = 64;
`ifdef PKT_CHECK_LEN_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [DATA_W-1:0]  st_data = '0;
    logic               st_valid = 1'b0;
    logic               st_ready = 1'b0;
    logic               st_sop = 1'b0;
    logic               st_eop = 1'b0;
    logic [EMPTY_W-1:0] st_empty = '0;
    logic [CHAN_W-1:0]  st_channel = '0;
    logic               clear_err = 1'b0;
    logic [4:0]         err_sticky;
    logic               err_pulse;
    logic [2:0]         first_err_code;
    logic [CHAN_W-1:0]  first_err_chan;
    logic [31:0]        pkt_count;

    pkt_stream_checker #(
        .DATA_W(DATA_W), .CHAN_W(CHAN_W), .NCHAN(NCHAN), .TAG_W(TAG_W), .TAG_LSB(0),
        .EMPTY_W(EMPTY_W), .MIN_BEATS(MIN_BEATS), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .st_data(st_data), .st_valid(st_valid),
        .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty),
        .st_channel(st_channel), .clear_err(clear_err), .err_sticky(err_sticky),
        .err_pulse(err_pulse), .first_err_code(first_err_code),
        .first_err_chan(first_err_chan), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          m_inpkt [NCHAN];
    int          m_etag  [NCHAN];
    int          m_eemp  [NCHAN];
    int          m_len   [NCHAN];
    logic [4:0]  m_sticky;
    logic        m_pulse;
    int          m_code;
    int          m_chan;
    logic [31:0] m_pkt;

    function automatic void model_reset();
        for (int i = 0; i < NCHAN; i++) begin
            m_inpkt[i] = 1'b0;
            m_etag[i]  = 0;
            m_eemp[i]  = 0;
            m_len[i]   = 0;
        end
        m_sticky = 5'b0;
        m_pulse  = 1'b0;
        m_code   = 0;
        m_chan   = 0;
        m_pkt    = 32'd0;
    endfunction

    function automatic void model_step(int ch, bit sop, bit eop, int tag, int emp,
                                       bit v, bit r, bit clr);
        logic [4:0] e;
        bit fin;
        e   = 5'b0;
        fin = 1'b0;
        if (v && r) begin
            if (ch >= NCHAN) begin
                e[4] = 1'b1;
            end else if (sop) begin
                if (m_inpkt[ch]) e[0] = 1'b1;
                if (tag != m_etag[ch]) e[1] = 1'b1;
                m_etag[ch]  = (tag + 1) % 64;
                m_len[ch]   = 1;
                m_inpkt[ch] = 1'b1;
                fin         = eop;
            end else if (!m_inpkt[ch]) begin
                e[0] = 1'b1;
            end else begin
                m_len[ch] = (m_len[ch] < 65535) ? m_len[ch] + 1 : 65535;
                fin       = eop;
            end
            if (fin) begin
                if (emp != m_eemp[ch]) e[2] = 1'b1;
                m_eemp[ch] = (m_eemp[ch] + 1) % 16;
                if (LEN_EN && (m_len[ch] < MIN_BEATS || m_len[ch] > MAX_BEATS)) e[3] = 1'b1;
                m_pkt       = m_pkt + 32'd1;
                m_inpkt[ch] = 1'b0;
            end
        end
        if (e != 5'b0 && (clr || m_sticky == 5'b0)) begin
            m_chan = ch;
            for (int b = 4; b >= 0; b--) if (e[b]) m_code = b;
        end else if (clr) begin
            m_code = 0;
            m_chan = 0;
        end
        m_sticky = (clr ? 5'b0 : m_sticky) | e;
        m_pulse  = (e != 5'b0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("first_err_code", 32'(first_err_code), 32'(m_code));
        chk("first_err_chan", 32'(first_err_chan), 32'(m_chan));
        chk("pkt_count", pkt_count, m_pkt);
    endtask

    // One clock cycle: drive at negedge, check registered outputs just after posedge
    task automatic beat(input int ch, input bit sop, input bit eop, input int tag,
                        input int emp, input bit v, input bit r, input bit clr);
        logic [DATA_W-1:0] d;
        @(negedge clk);
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        d[TAG_W-1:0] = TAG_W'(tag);
        st_data    = d;
        st_channel = CHAN_W'(ch);
        st_sop     = sop;
        st_eop     = eop;
        st_empty   = EMPTY_W'(emp);
        st_valid   = v;
        st_ready   = r;
        clear_err  = clr;
        model_step(ch, sop, eop, tag, emp, v, r, clr);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle(input bit clr);
        beat(0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, clr);
    endtask

    task automatic rand_beat();
        int ch;
        int tag;
        int emp;
        ch  = $urandom_range(0, 5);
        tag = $urandom_range(0, 63);
        emp = $urandom_range(0, 15);
        if (ch < NCHAN && $urandom_range(0, 1) == 1) tag = m_etag[ch];
        if (ch < NCHAN && $urandom_range(0, 3) != 0) emp = m_eemp[ch];
        beat(ch, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), tag, emp,
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 19) == 0));
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        chk("rst_pulse", 32'(err_pulse), 32'd0);
        chk("rst_pkt", pkt_count, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Non-accepted beats are ignored
        beat(0, 1'b0, 1'b1, 9, 7, 1'b1, 1'b0, 1'b0);
        beat(0, 1'b0, 1'b1, 9, 7, 1'b0, 1'b1, 1'b0);

        // Three clean six-beat packets on ch0
        for (int p = 0; p < 3; p++) begin
            beat(0, 1'b1, 1'b0, p, 0, 1'b1, 1'b1, 1'b0);
            for (int b = 0; b < 4; b++) beat(0, 1'b0, 1'b0, 33, 0, 1'b1, 1'b1, 1'b0);
            beat(0, 1'b0, 1'b1, 33, p, 1'b1, 1'b1, 1'b0);
        end
        chk("clean_pkt", pkt_count, 32'd3);
        chk("clean_sticky", 32'(err_sticky), 32'd0);

        // Tag jump on ch1
        beat(1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        beat(1, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
        beat(1, 1'b1, 1'b0, 5, 0, 1'b1, 1'b1, 1'b0);
        chk("tag_sticky", 32'(err_sticky), 32'h02);
        chk("tag_code", 32'(first_err_code), 32'd1);
        chk("tag_chan", 32'(first_err_chan), 32'd1);
        beat(1, 1'b0, 1'b1, 0, 1, 1'b1, 1'b1, 1'b0);
        beat(1, 1'b1, 1'b0, 6, 0, 1'b1, 1'b1, 1'b0);
        chk("tag_resync_pulse", 32'(err_pulse), 32'd0);
        beat(1, 1'b0, 1'b1, 0, 2, 1'b1, 1'b1, 1'b0);
        chk("tag_resync_sticky", 32'(err_sticky), 32'h02);

        // Framing on ch2
        idle(1'b1);
        beat(2, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("frm_pulse1", 32'(err_pulse), 32'd1);
        beat(2, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        beat(2, 1'b1, 1'b0, 1, 0, 1'b1, 1'b1, 1'b0);
        chk("frm_pulse2", 32'(err_pulse), 32'd1);
        chk("frm_code", 32'(first_err_code), 32'd0);
        chk("frm_chan", 32'(first_err_chan), 32'd2);
        beat(2, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0);

        // Bad channel and clear
        idle(1'b1);
        beat(NCHAN, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("badchan_sticky", 32'(err_sticky), 32'h10);
        chk("badchan_code", 32'(first_err_code), 32'd4);
        idle(1'b1);
        chk("clear_sticky", 32'(err_sticky), 32'd0);

        // Length boundaries on ch3
        beat(3, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("len1_sticky3", 32'(err_sticky[3]), 32'(LEN_EN));
        idle(1'b1);
        beat(3, 1'b1, 1'b0, 1, 0, 1'b1, 1'b1, 1'b0);
        for (int b = 0; b < 63; b++) beat(3, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        beat(3, 1'b0, 1'b1, 0, 1, 1'b1, 1'b1, 1'b0);
        chk("len65_sticky3", 32'(err_sticky[3]), 32'(LEN_EN));
        idle(1'b1);
        beat(3, 1'b1, 1'b0, 2, 0, 1'b1, 1'b1, 1'b0);
        for (int b = 0; b < 62; b++) beat(3, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        beat(3, 1'b0, 1'b1, 0, 2, 1'b1, 1'b1, 1'b0);
        chk("len64_sticky", 32'(err_sticky), 32'd0);

        // Reset in the middle of a ch0 packet
        beat(0, 1'b1, 1'b0, 3, 0, 1'b1, 1'b1, 1'b0);
        beat(0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        st_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_pkt", pkt_count, 32'd0);
        chk("arst_sticky", 32'(err_sticky), 32'd0);
        check_model();
        @(negedge clk);
        reset_n = 1'b1;
        beat(0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("arst_frm_sticky", 32'(err_sticky), 32'h01);
        chk("arst_frm_pkt", pkt_count, 32'd0);

        // Random traffic
        for (int n = 0; n < 800; n++) rand_beat();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
